// File: rtl/vc_input_buffer.sv
// Router receive stage: one flit FIFO per virtual channel, re-presented to the
// crossbar one packet at a time, with the output locked to a VC until its tail.
package ravenoc_pkg;
  localparam int N_VIRT_CHN    = 2;
  localparam int H_PRIORITY    = 1;
  localparam int VC_WIDTH      = (N_VIRT_CHN > 1) ? $clog2(N_VIRT_CHN) : 1;
  localparam int FLIT_WIDTH    = 32;
  localparam int FLIT_TP_WIDTH = 2;
  localparam int PKT_SZ_WIDTH  = 8;
  localparam int MIN_SIZE_FLIT = 1;

  // Flit type sits in the top bits of fdata; a head also carries pkt_size below it.
  typedef enum logic [FLIT_TP_WIDTH-1:0] {
    HEAD_FLIT = 2'd0,
    BODY_FLIT = 2'd1,
    TAIL_FLIT = 2'd2
  } flit_type_t;

  typedef struct packed {
    logic                  valid;
    logic [VC_WIDTH-1:0]   vc_id;
    logic [FLIT_WIDTH-1:0] fdata;
  } s_flit_req_t;

  typedef struct packed {
    logic ready;
  } s_flit_resp_t;
endpackage

module vc_input_buffer #(
  parameter int BUFF_DEPTH = 4,
  parameter int N_VIRT_CHN = ravenoc_pkg::N_VIRT_CHN,
  parameter int H_PRIORITY = ravenoc_pkg::H_PRIORITY
) (
  input  logic                      clk,
  input  logic                      arst,
  input  ravenoc_pkg::s_flit_req_t  fin_req_i,
  output ravenoc_pkg::s_flit_resp_t fin_resp_o,
  output ravenoc_pkg::s_flit_req_t  fout_req_o,
  input  ravenoc_pkg::s_flit_resp_t fout_resp_i,
  output logic [N_VIRT_CHN-1:0]     vc_full_o,
  output logic [N_VIRT_CHN-1:0]     vc_empty_o,
  output logic                      proto_err_o
);
  localparam int PTR_W = $clog2(BUFF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int VC_W  = ravenoc_pkg::VC_WIDTH;
  localparam int FW    = ravenoc_pkg::FLIT_WIDTH;
  localparam int TW    = ravenoc_pkg::FLIT_TP_WIDTH;
  localparam int SW    = ravenoc_pkg::PKT_SZ_WIDTH;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  logic [FW-1:0]    r_mem    [N_VIRT_CHN][BUFF_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr [N_VIRT_CHN];
  logic [PTR_W-1:0] r_rd_ptr [N_VIRT_CHN];
  logic [CNT_W-1:0] r_cnt    [N_VIRT_CHN];
  state_t           r_state;
  logic [VC_W-1:0]  r_lock_vc;
  logic [VC_W-1:0]  r_hold_vc;
  logic             r_hold;

  logic [N_VIRT_CHN-1:0]   w_full;
  logic [N_VIRT_CHN-1:0]   w_empty;
  logic [N_VIRT_CHN-1:0]   w_push_vc;
  logic [N_VIRT_CHN-1:0]   w_pop_vc;
  logic [VC_W-1:0]         w_prio_vc;
  logic [VC_W-1:0]         w_sel_vc;
  logic                    w_in_ready;
  logic                    w_push;
  logic                    w_out_valid;
  logic                    w_pop;
  logic [FW-1:0]           w_front;
  ravenoc_pkg::flit_type_t w_ftype;
  logic [SW-1:0]           w_pkt_size;
  logic                    w_is_head;
  logic                    w_is_mid_or_tail;
  logic                    w_is_tail;
  logic                    w_multi;
  logic                    w_err;

  always_comb begin
    for (int v = 0; v < N_VIRT_CHN; v++) begin
      w_full[v]  = (r_cnt[v] == CNT_W'(BUFF_DEPTH));
      w_empty[v] = (r_cnt[v] == '0);
    end
  end

  // No bypass: a full FIFO refuses even when it pops in the same cycle.
  assign w_in_ready = !arst && !w_full[fin_req_i.vc_id];
  assign w_push     = fin_req_i.valid && w_in_ready;

  always_comb begin
    w_prio_vc = '0;
    if (H_PRIORITY == 1) begin
      for (int v = 0; v < N_VIRT_CHN; v++)
        if (!w_empty[v]) w_prio_vc = VC_W'(v);
    end else begin
      for (int v = N_VIRT_CHN - 1; v >= 0; v--)
        if (!w_empty[v]) w_prio_vc = VC_W'(v);
    end
  end

  // A flit offered but not taken keeps its VC so fdata/vc_id stay stable.
  always_comb begin
    w_sel_vc = w_prio_vc;
    if (r_state == ST_LOCKED) w_sel_vc = r_lock_vc;
    else if (r_hold)          w_sel_vc = r_hold_vc;
  end

  assign w_out_valid = !arst && !w_empty[w_sel_vc];
  assign w_pop       = w_out_valid && fout_resp_i.ready;
  assign w_front     = r_mem[w_sel_vc][r_rd_ptr[w_sel_vc]];

  assign w_ftype          = ravenoc_pkg::flit_type_t'(w_front[FW-1 -: TW]);
  assign w_pkt_size       = w_front[FW-TW-1 -: SW];
  assign w_is_head        = (w_ftype == ravenoc_pkg::HEAD_FLIT);
  assign w_is_tail        = (w_ftype == ravenoc_pkg::TAIL_FLIT);
  assign w_is_mid_or_tail = (w_ftype == ravenoc_pkg::BODY_FLIT) || w_is_tail;
  assign w_multi          = (w_pkt_size != SW'(ravenoc_pkg::MIN_SIZE_FLIT));

  assign w_err = w_pop && (((r_state == ST_IDLE) && w_is_mid_or_tail) ||
                           ((r_state == ST_LOCKED) && w_is_head));

  always_comb begin
    for (int v = 0; v < N_VIRT_CHN; v++) begin
      w_push_vc[v] = w_push && (fin_req_i.vc_id == VC_W'(v));
      w_pop_vc[v]  = w_pop && (w_sel_vc == VC_W'(v));
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < N_VIRT_CHN; v++)
      if (w_push_vc[v]) r_mem[v][r_wr_ptr[v]] <= fin_req_i.fdata;
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      for (int v = 0; v < N_VIRT_CHN; v++) begin
        r_wr_ptr[v] <= '0;
        r_rd_ptr[v] <= '0;
        r_cnt[v]    <= '0;
      end
    end else begin
      for (int v = 0; v < N_VIRT_CHN; v++) begin
        if (w_push_vc[v]) r_wr_ptr[v] <= r_wr_ptr[v] + PTR_W'(1);
        if (w_pop_vc[v])  r_rd_ptr[v] <= r_rd_ptr[v] + PTR_W'(1);
        case ({w_push_vc[v], w_pop_vc[v]})
          2'b10:   r_cnt[v] <= r_cnt[v] + CNT_W'(1);
          2'b01:   r_cnt[v] <= r_cnt[v] - CNT_W'(1);
          default: r_cnt[v] <= r_cnt[v];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      r_state   <= ST_IDLE;
      r_lock_vc <= '0;
      r_hold    <= 1'b0;
      r_hold_vc <= '0;
    end else begin
      r_hold <= w_out_valid && !fout_resp_i.ready;
      if (w_out_valid && !fout_resp_i.ready) r_hold_vc <= w_sel_vc;
      case (r_state)
        ST_IDLE: begin
          if (w_pop && w_is_head && w_multi) begin
            r_state   <= ST_LOCKED;
            r_lock_vc <= w_sel_vc;
          end
        end
        ST_LOCKED: begin
          if (w_pop && w_is_tail) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    fout_req_o = '0;
    if (w_out_valid) begin
      fout_req_o.valid = 1'b1;
      fout_req_o.vc_id = w_sel_vc;
      fout_req_o.fdata = w_front;
    end
  end

  assign fin_resp_o.ready = w_in_ready;
  assign vc_full_o        = w_full;
  assign vc_empty_o       = w_empty;
  assign proto_err_o      = w_err;

endmodule

// File: tb/tb_vc_input_buffer.sv
// Bench for vc_input_buffer: vector table, directed corner sequences and a
// randomized run against a queue-based model of the receive buffer.
module tb_vc_input_buffer;
  import ravenoc_pkg::*;

  localparam int DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  arst;
  s_flit_req_t           fin_req;
  s_flit_resp_t          fin_resp;
  s_flit_req_t           fout_req;
  s_flit_resp_t          fout_resp;
  logic [N_VIRT_CHN-1:0] vc_full;
  logic [N_VIRT_CHN-1:0] vc_empty;
  logic                  proto_err;

  always #5 clk = ~clk;

  vc_input_buffer #(.BUFF_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .arst       (arst),
    .fin_req_i  (fin_req),
    .fin_resp_o (fin_resp),
    .fout_req_o (fout_req),
    .fout_resp_i(fout_resp),
    .vc_full_o  (vc_full),
    .vc_empty_o (vc_empty),
    .proto_err_o(proto_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input bit ov, input int vc, input logic [31:0] d);
    logic [VC_WIDTH-1:0] evc;
    evc = VC_WIDTH'(vc);
    chk(name, {fout_req.valid, fout_req.vc_id, fout_req.fdata}, {ov, evc, d});
  endtask

  function automatic logic [31:0] mk(input flit_type_t t, input int size, input int pay);
    return {t, 8'(size), 22'(pay)};
  endfunction

  // Reference model: plain queues per VC plus the packet-lock and offer-hold rules.
  logic [31:0] mq[N_VIRT_CHN][$];
  bit          m_en = 0;
  bit          m_locked = 0;
  int          m_lock_vc = 0;
  bit          m_held = 0;
  int          m_held_vc = 0;
  int          e_sel;
  bit          e_valid, e_pop, e_push;
  logic [31:0] e_front;

  task automatic model_check();
    int sel;
    int v;
    bit e_ready, e_err;
    flit_type_t ft;
    s_flit_req_t exp_out;
    logic [N_VIRT_CHN-1:0] ef, ee;
    sel = -1;
    if (m_locked) sel = m_lock_vc;
    else if (m_held) sel = m_held_vc;
    else begin
      for (int k = 0; k < N_VIRT_CHN; k++) begin
        v = (H_PRIORITY == 1) ? N_VIRT_CHN - 1 - k : k;
        if (sel < 0 && mq[v].size() > 0) sel = v;
      end
    end
    if (sel < 0) sel = 0;
    e_front = (mq[sel].size() > 0) ? mq[sel][0] : '0;
    e_valid = !arst && (mq[sel].size() > 0);
    e_ready = !arst && (mq[int'(fin_req.vc_id)].size() < DEPTH);
    e_pop   = e_valid && fout_resp.ready;
    e_push  = fin_req.valid && e_ready;
    ft      = flit_type_t'(e_front[31:30]);
    e_err   = e_pop && (m_locked ? (ft == HEAD_FLIT) : (ft == BODY_FLIT || ft == TAIL_FLIT));
    exp_out = '0;
    if (e_valid) begin
      exp_out.valid = 1'b1;
      exp_out.vc_id = VC_WIDTH'(sel);
      exp_out.fdata = e_front;
    end
    for (int k = 0; k < N_VIRT_CHN; k++) begin
      ef[k] = (mq[k].size() == DEPTH);
      ee[k] = (mq[k].size() == 0);
    end
    e_sel = sel;
    if (m_en) begin
      chk("model_ready", fin_resp.ready, e_ready);
      chk("model_fout", fout_req, exp_out);
      chk("model_err", proto_err, e_err);
      chk("model_full", vc_full, ef);
      chk("model_empty", vc_empty, ee);
    end
  endtask

  task automatic model_update();
    flit_type_t ft;
    if (arst) begin
      for (int k = 0; k < N_VIRT_CHN; k++) mq[k].delete();
      m_locked = 0;
      m_held   = 0;
    end else begin
      ft = flit_type_t'(e_front[31:30]);
      if (e_pop) begin
        void'(mq[e_sel].pop_front());
        if (!m_locked && ft == HEAD_FLIT && e_front[29:22] != 8'(MIN_SIZE_FLIT)) begin
          m_locked  = 1;
          m_lock_vc = e_sel;
        end else if (m_locked && ft == TAIL_FLIT) begin
          m_locked = 0;
        end
      end
      if (e_push) mq[int'(fin_req.vc_id)].push_back(fin_req.fdata);
      m_held    = e_valid && !fout_resp.ready;
      m_held_vc = e_sel;
    end
    m_en = 1;
  endtask

  task automatic setin(input bit a, input bit v, input int vc, input logic [31:0] d, input bit r);
    @(negedge clk);
    arst            = a;
    fin_req.valid   = v;
    fin_req.vc_id   = VC_WIDTH'(vc);
    fin_req.fdata   = d;
    fout_resp.ready = r;
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
  endtask

  typedef struct {
    bit a; bit v; int vc; logic [31:0] d; bit r;
    bit x_ready; bit x_ov; int x_ovc; logic [31:0] x_od; bit x_err;
    logic [1:0] x_full; logic [1:0] x_empty;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [31:0] d0, f1, f2, f3, f4, f5;
    logic [31:0] p0, p1, p2, q0, q1, q2, l0, l1, l2, g0, e0, r0, r1, r2, s0;
    logic [31:0] rd;
    int kind;

    arst = 1'b1;
    fin_req = '0;
    fout_resp = '0;
    repeat (2) tick();

    d0 = mk(HEAD_FLIT, 1, 'h11);
    f1 = mk(HEAD_FLIT, 1, 'h21);
    f2 = mk(HEAD_FLIT, 1, 'h22);
    f3 = mk(HEAD_FLIT, 1, 'h23);
    f4 = mk(HEAD_FLIT, 1, 'h24);
    f5 = mk(HEAD_FLIT, 1, 'h25);
    //           a  v  vc d   r  rdy ov ovc od  err full   empty
    tbl[0]  = '{1, 1, 0, d0, 1, 0,  0, 0,  0,  0,  2'b00, 2'b11};
    tbl[1]  = '{0, 1, 0, d0, 0, 1,  0, 0,  0,  0,  2'b00, 2'b11};
    tbl[2]  = '{0, 0, 0, 0,  1, 1,  1, 0,  d0, 0,  2'b00, 2'b10};
    tbl[3]  = '{0, 1, 1, f1, 0, 1,  0, 0,  0,  0,  2'b00, 2'b11};
    tbl[4]  = '{0, 1, 1, f2, 0, 1,  1, 1,  f1, 0,  2'b00, 2'b01};
    tbl[5]  = '{0, 1, 1, f3, 0, 1,  1, 1,  f1, 0,  2'b00, 2'b01};
    tbl[6]  = '{0, 1, 1, f4, 0, 1,  1, 1,  f1, 0,  2'b00, 2'b01};
    tbl[7]  = '{0, 1, 1, f5, 0, 0,  1, 1,  f1, 0,  2'b10, 2'b01};
    tbl[8]  = '{0, 0, 0, 0,  0, 1,  1, 1,  f1, 0,  2'b10, 2'b01};
    tbl[9]  = '{0, 0, 1, 0,  1, 0,  1, 1,  f1, 0,  2'b10, 2'b01};
    tbl[10] = '{0, 0, 0, 0,  1, 1,  1, 1,  f2, 0,  2'b00, 2'b01};
    tbl[11] = '{0, 0, 0, 0,  1, 1,  1, 1,  f3, 0,  2'b00, 2'b01};
    tbl[12] = '{0, 0, 0, 0,  1, 1,  1, 1,  f4, 0,  2'b00, 2'b01};
    tbl[13] = '{0, 0, 0, 0,  1, 1,  0, 0,  0,  0,  2'b00, 2'b11};

    for (int i = 0; i < 14; i++) begin
      setin(tbl[i].a, tbl[i].v, tbl[i].vc, tbl[i].d, tbl[i].r);
      chk($sformatf("tbl%0d_ready", i), fin_resp.ready, tbl[i].x_ready);
      chk_out($sformatf("tbl%0d_fout", i), tbl[i].x_ov, tbl[i].x_ovc, tbl[i].x_od);
      chk($sformatf("tbl%0d_err", i), proto_err, tbl[i].x_err);
      chk($sformatf("tbl%0d_full", i), vc_full, tbl[i].x_full);
      chk($sformatf("tbl%0d_empty", i), vc_empty, tbl[i].x_empty);
      tick();
    end

    // Simultaneous push and pop on VC0 holding two flits; pointers wrap.
    setin(0, 1, 0, mk(HEAD_FLIT, 1, 'h100), 0); tick();
    setin(0, 1, 0, mk(HEAD_FLIT, 1, 'h101), 0);
    chk_out("pp_first", 1, 0, mk(HEAD_FLIT, 1, 'h100)); tick();
    for (int i = 0; i < 10; i++) begin
      setin(0, 1, 0, mk(HEAD_FLIT, 1, 'h102 + i), 1);
      chk_out($sformatf("pp_data%0d", i), 1, 0, mk(HEAD_FLIT, 1, 'h100 + i));
      chk($sformatf("pp_stat%0d", i), {vc_full[0], vc_empty[0]}, 2'b00);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      setin(0, 0, 0, 0, 1);
      chk_out($sformatf("pp_drain%0d", i), 1, 0, mk(HEAD_FLIT, 1, 'h10a + i)); tick();
    end
    setin(0, 0, 0, 0, 1); chk("pp_empty", vc_empty, 2'b11); tick();

    // Priority: VC1 outranks a waiting VC0 packet once the held offer is taken.
    p0 = mk(HEAD_FLIT, 3, 'h200); p1 = mk(BODY_FLIT, 0, 'h201); p2 = mk(TAIL_FLIT, 0, 'h202);
    setin(0, 1, 1, f1, 0); tick();
    setin(0, 1, 1, f2, 0); tick();
    setin(0, 1, 0, p0, 0); tick();
    setin(0, 1, 0, p1, 0); tick();
    setin(0, 1, 0, p2, 0); tick();
    setin(0, 0, 0, 0, 1); chk_out("prio_b0", 1, 1, f1); tick();
    setin(0, 0, 0, 0, 1); chk_out("prio_b1", 1, 1, f2); tick();
    setin(0, 0, 0, 0, 1); chk_out("prio_p0", 1, 0, p0); tick();
    setin(0, 0, 0, 0, 1); chk_out("prio_p1", 1, 0, p1); tick();
    setin(0, 0, 0, 0, 1); chk_out("prio_p2", 1, 0, p2); chk("prio_err", proto_err, 0); tick();

    // Lock with starvation: VC1 flits wait until the VC0 tail leaves.
    q0 = mk(HEAD_FLIT, 3, 'h300); q1 = mk(BODY_FLIT, 0, 'h301); q2 = mk(TAIL_FLIT, 0, 'h302);
    setin(0, 1, 0, q0, 1); chk_out("lk_idle", 0, 0, 0); tick();
    setin(0, 1, 1, f3, 1); chk_out("lk_head", 1, 0, q0); tick();
    setin(0, 1, 1, f4, 1); chk_out("lk_starve0", 0, 0, 0); tick();
    setin(0, 1, 1, f5, 1); chk_out("lk_starve1", 0, 0, 0); tick();
    setin(0, 1, 0, q1, 1); chk_out("lk_starve2", 0, 0, 0); tick();
    setin(0, 1, 0, q2, 1); chk_out("lk_body", 1, 0, q1); tick();
    setin(0, 0, 0, 0, 1);  chk_out("lk_tail", 1, 0, q2); tick();
    setin(0, 0, 0, 0, 1);  chk_out("lk_vc1a", 1, 1, f3); tick();
    setin(0, 0, 0, 0, 1);  chk_out("lk_vc1b", 1, 1, f4); tick();
    setin(0, 0, 0, 0, 1);  chk_out("lk_vc1c", 1, 1, f5); tick();

    // Protocol errors: body in IDLE, head inside a locked packet.
    e0 = mk(BODY_FLIT, 0, 'h400);
    l0 = mk(HEAD_FLIT, 3, 'h410); l1 = mk(HEAD_FLIT, 1, 'h411); l2 = mk(TAIL_FLIT, 0, 'h412);
    g0 = mk(HEAD_FLIT, 1, 'h420);
    setin(0, 1, 0, e0, 0); tick();
    setin(0, 0, 0, 0, 1); chk_out("pe_body", 1, 0, e0); chk("pe_body_err", proto_err, 1); tick();
    setin(0, 0, 0, 0, 1); chk("pe_pulse_end", proto_err, 0); tick();
    setin(0, 1, 0, l0, 0); tick();
    setin(0, 1, 1, g0, 0); tick();
    setin(0, 1, 0, l1, 0); tick();
    setin(0, 1, 0, l2, 0); tick();
    setin(0, 0, 0, 0, 1); chk_out("pe_l0", 1, 0, l0); chk("pe_l0_err", proto_err, 0); tick();
    setin(0, 0, 0, 0, 1); chk_out("pe_l1", 1, 0, l1); chk("pe_head_err", proto_err, 1); tick();
    setin(0, 0, 0, 0, 1); chk_out("pe_l2", 1, 0, l2); chk("pe_l2_err", proto_err, 0); tick();
    setin(0, 0, 0, 0, 1); chk_out("pe_g0", 1, 1, g0); tick();

    // Reset in mid-packet drops the lock and every buffered flit.
    r0 = mk(HEAD_FLIT, 3, 'h500); r1 = mk(BODY_FLIT, 0, 'h501); r2 = mk(BODY_FLIT, 0, 'h502);
    s0 = mk(HEAD_FLIT, 1, 'h510);
    setin(0, 1, 0, r0, 0); tick();
    setin(0, 1, 0, r1, 1); tick();
    setin(0, 1, 0, r2, 0); chk_out("rst_pre", 1, 0, r1); tick();
    setin(1, 1, 1, s0, 1);
    chk("rst_ready", fin_resp.ready, 0); chk_out("rst_fout", 0, 0, 0); chk("rst_err", proto_err, 0);
    tick();
    setin(0, 0, 0, 0, 0);
    chk("rst_empty", vc_empty, 2'b11); chk("rst_full", vc_full, 2'b00); chk_out("rst_fout2", 0, 0, 0);
    tick();
    setin(0, 1, 1, s0, 0); tick();
    setin(0, 0, 0, 0, 1); chk_out("rst_unlocked", 1, 1, s0); tick();

    // Randomized traffic checked cycle by cycle against the model.
    for (int c = 0; c < 1500; c++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: rd = mk(HEAD_FLIT, 1, $urandom);
        1: rd = mk(HEAD_FLIT, 3, $urandom);
        2: rd = mk(BODY_FLIT, 0, $urandom);
        default: rd = mk(TAIL_FLIT, 0, $urandom);
      endcase
      setin(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 6),
            $urandom_range(0, N_VIRT_CHN - 1), rd, ($urandom_range(0, 9) < 7));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
